// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART peripheral.
// Word registers: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL, 4 DIV.
// Read data is combinational so a single-cycle load completes in the same cycle.
// TX and RX each latch the divisor when a frame starts, so a DIV write
// mid-frame only affects later frames.
module uart_mmio #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DIV_RST  = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Select,
    input  logic        Write,
    input  logic [31:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    input  logic        rx,
    output logic        tx
);

    localparam logic [15:0] DIV_RST_W = 16'(DIV_RST);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // A divisor below 2 would leave no room for the half-bit start check.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        logic [15:0] result;
        if (value < 16'd2) begin
            result = 16'd2;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    logic [2:0] idx_s;
    logic       wr_en_s;
    logic       wr_tx_s;
    logic       wr_ctrl_s;
    logic       wr_div_s;
    logic       clr_valid_s;
    logic       clr_err_s;
    logic       unused_s;

    assign idx_s       = Addr[2:0];
    assign wr_en_s     = Select & Write;
    assign wr_tx_s     = wr_en_s && (idx_s == 3'd0);
    assign wr_ctrl_s   = wr_en_s && (idx_s == 3'd3);
    assign wr_div_s    = wr_en_s && (idx_s == 3'd4);
    assign clr_valid_s = wr_ctrl_s & DataIn[0];
    assign clr_err_s   = wr_ctrl_s & DataIn[1];
    assign unused_s    = ^{Addr[31:3], DataIn[31:16]};

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    logic [15:0] div_r, div_s;

    tx_state_t   tx_state_r, tx_state_s;
    logic [15:0] tx_cnt_r, tx_cnt_s;
    logic [15:0] tx_div_r, tx_div_s;
    logic [2:0]  tx_bit_r, tx_bit_s;
    logic [7:0]  tx_shift_r, tx_shift_s;
    logic        tx_r, tx_s;
    logic        tx_busy_r, tx_busy_s;

    logic        rx_meta_r, rx_sync_r;
    rx_state_t   rx_state_r, rx_state_s;
    logic [15:0] rx_cnt_r, rx_cnt_s;
    logic [15:0] rx_div_r, rx_div_s;
    logic [2:0]  rx_bit_r, rx_bit_s;
    logic [7:0]  rx_shift_r, rx_shift_s;
    logic        rx_done_s;
    logic        rx_ferr_s;

    logic [7:0]  rx_byte_r, rx_byte_s;
    logic        rx_valid_r, rx_valid_s;
    logic        overrun_r, overrun_s;
    logic        frame_err_r, frame_err_s;

    // Divisor register next value, clamped to a minimum of 2.
    always_comb begin
        if (wr_div_s) begin
            div_s = clamp_div(DataIn[15:0]);
        end else begin
            div_s = div_r;
        end
    end

    // Divisor register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= DIV_RST_W;
        end else begin
            div_r <= div_s;
        end
    end

    // ---------------------------------------------------------------
    // Transmitter
    // ---------------------------------------------------------------

    // TX next-state and datapath: start, 8 data bits LSB-first, stop.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_div_s   = tx_div_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_s       = tx_r;
        tx_busy_s  = tx_busy_r;
        case (tx_state_r)
            TX_IDLE: begin
                tx_s      = 1'b1;
                tx_busy_s = 1'b0;
                if (wr_tx_s) begin
                    tx_shift_s = DataIn[7:0];
                    tx_div_s   = div_r;
                    tx_cnt_s   = div_r - 16'd1;
                    tx_bit_s   = 3'd0;
                    tx_s       = 1'b0;
                    tx_busy_s  = 1'b1;
                    tx_state_s = TX_START;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_s       = tx_shift_r[0];
                    tx_cnt_s   = tx_div_r - 16'd1;
                    tx_bit_s   = 3'd0;
                    tx_state_s = TX_DATA;
                end else begin
                    tx_cnt_s = tx_cnt_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_cnt_s = tx_div_r - 16'd1;
                    if (tx_bit_r == 3'd7) begin
                        tx_s       = 1'b1;
                        tx_state_s = TX_STOP;
                    end else begin
                        tx_s       = tx_shift_r[1];
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        tx_bit_s   = tx_bit_r + 3'd1;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_s       = 1'b1;
                    tx_busy_s  = 1'b0;
                    tx_state_s = TX_IDLE;
                end else begin
                    tx_cnt_s = tx_cnt_r - 16'd1;
                end
            end
            default: begin
                tx_s       = 1'b1;
                tx_busy_s  = 1'b0;
                tx_state_s = TX_IDLE;
            end
        endcase
    end

    // TX state and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_div_r   <= DIV_RST_W;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_div_r   <= tx_div_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_r       <= tx_s;
            tx_busy_r  <= tx_busy_s;
        end
    end

    assign tx = tx_r;

    // ---------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------

    // Two-flop synchronizer for the asynchronous rx pin, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX next-state: half-bit start check, then mid-bit data and stop samples.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_div_s   = rx_div_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_done_s  = 1'b0;
        rx_ferr_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_sync_r) begin
                    rx_div_s   = div_r;
                    rx_cnt_s   = (div_r >> 1) - 16'd1;
                    rx_bit_s   = 3'd0;
                    rx_state_s = RX_START;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == 16'd0) begin
                    if (rx_sync_r) begin
                        rx_state_s = RX_IDLE;
                    end else begin
                        rx_cnt_s   = rx_div_r - 16'd1;
                        rx_bit_s   = 3'd0;
                        rx_state_s = RX_DATA;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    rx_cnt_s   = rx_div_r - 16'd1;
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = RX_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == 16'd0) begin
                    if (rx_sync_r) begin
                        rx_done_s = 1'b1;
                    end else begin
                        rx_ferr_s = 1'b1;
                    end
                    rx_state_s = RX_IDLE;
                end else begin
                    rx_cnt_s = rx_cnt_r - 16'd1;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
            end
        endcase
    end

    // RX state and datapath registers; reset discards a partial byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_div_r   <= DIV_RST_W;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_div_r   <= rx_div_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
        end
    end

    // Receive byte and flags; a hardware set beats a same-edge CTRL clear.
    always_comb begin
        if (rx_done_s) begin
            rx_byte_s = rx_shift_r;
        end else begin
            rx_byte_s = rx_byte_r;
        end

        if (rx_done_s) begin
            rx_valid_s = 1'b1;
        end else if (clr_valid_s) begin
            rx_valid_s = 1'b0;
        end else begin
            rx_valid_s = rx_valid_r;
        end

        // A byte landing while software clears rx_valid is not an overrun.
        if (rx_done_s && rx_valid_r && !clr_valid_s) begin
            overrun_s = 1'b1;
        end else if (clr_err_s) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end

        if (rx_ferr_s) begin
            frame_err_s = 1'b1;
        end else if (clr_err_s) begin
            frame_err_s = 1'b0;
        end else begin
            frame_err_s = frame_err_r;
        end
    end

    // Receive byte and status flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte_r   <= 8'd0;
            rx_valid_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_byte_r   <= rx_byte_s;
            rx_valid_r  <= rx_valid_s;
            overrun_r   <= overrun_s;
            frame_err_r <= frame_err_s;
        end
    end

    // ---------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------

    // Combinational read data; zero when not selected or for write-only slots.
    always_comb begin
        DataOut = 32'd0;
        if (Select) begin
            case (idx_s)
                3'd1:    DataOut = {24'd0, rx_byte_r};
                3'd2:    DataOut = {28'd0, frame_err_r, overrun_r, rx_valid_r, tx_busy_r};
                3'd4:    DataOut = {16'd0, div_r};
                default: DataOut = 32'd0;
            endcase
        end else begin
            DataOut = 32'd0;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio.
module tb_uart_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        Select;
    logic        Write;
    logic [31:0] Addr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        rx;
    logic        tx;

    int vectors    = 0;
    int miscompares = 0;

    uart_mmio dut (
        .clk     (clk),
        .rst     (rst),
        .Select  (Select),
        .Write   (Write),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .rx      (rx),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    // One bus write: driven at a falling edge, takes effect on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Select = 1'b1;
        Write  = 1'b1;
        Addr   = a;
        DataIn = d;
        @(negedge clk);
        Select = 1'b0;
        Write  = 1'b0;
    endtask

    // Combinational read, sampled mid low phase.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        Select = 1'b1;
        Write  = 1'b0;
        Addr   = a;
        #1;
        d = DataOut;
        Select = 1'b0;
    endtask

    // Drive one 8N1 frame on rx, div clocks per bit.
    task automatic send_frame(input logic [7:0] b, input logic stopb, input int div);
        @(negedge clk);
        rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (div) @(negedge clk);
        end
        rx = stopb;
        repeat (div) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tx: got %b expected 1", tx);
        end
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_status: got %h expected %h", rd, 32'h0);
        end
        bus_read(32'd4, rd);
        vectors++;
        if (rd !== 32'd434) begin
            miscompares++;
            $display("FAIL reset_div: got %0d expected 434", rd);
        end
        bus_read(32'd1, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rxdata: got %h expected 0", rd);
        end
    endtask

    task automatic test_tx_frame();
        logic [31:0] rd;
        logic [9:0]  frame;
        logic        exp_tx;
        frame = {1'b1, 8'hA5, 1'b0};
        bus_write(32'd4, 32'd4);
        bus_write(32'd0, 32'hA5);
        // Now half a cycle after the write edge: clock k of the frame.
        for (int k = 0; k < 40; k++) begin
            exp_tx = frame[k / 4];
            vectors++;
            if (tx !== exp_tx) begin
                miscompares++;
                $display("FAIL tx_bit clk %0d: got %b expected %b", k, tx, exp_tx);
            end
            bus_read(32'd2, rd);
            vectors++;
            if (rd !== 32'h1) begin
                miscompares++;
                $display("FAIL tx_busy clk %0d: got %h expected 1", k, rd);
            end
            if (k == 10) begin
                Select = 1'b1;
                Write  = 1'b1;
                Addr   = 32'd0;
                DataIn = 32'hFF;
            end
            @(negedge clk);
        end
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL tx_done_status: got %h expected 0", rd);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_idle_after: got %b expected 1", tx);
        end
    endtask

    task automatic test_rx_good();
        logic [31:0] rd;
        send_frame(8'h3C, 1'b1, 4);
        repeat (3) @(negedge clk);
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL rx_good_status: got %h expected 2", rd);
        end
        bus_read(32'd1, rd);
        vectors++;
        if (rd !== 32'h3C) begin
            miscompares++;
            $display("FAIL rx_good_data: got %h expected 3c", rd);
        end
        bus_read(32'd1, rd);
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL rx_read_no_side_effect: got %h expected 2", rd);
        end
        bus_write(32'd3, 32'h1);
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL rx_ctrl_clear: got %h expected 0", rd);
        end
    endtask

    task automatic test_rx_overrun_framing();
        logic [31:0] rd;
        send_frame(8'h11, 1'b1, 4);
        repeat (3) @(negedge clk);
        send_frame(8'h22, 1'b1, 4);
        repeat (3) @(negedge clk);
        bus_read(32'd1, rd);
        vectors++;
        if (rd !== 32'h22) begin
            miscompares++;
            $display("FAIL overrun_data: got %h expected 22", rd);
        end
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h6) begin
            miscompares++;
            $display("FAIL overrun_status: got %h expected 6", rd);
        end
        send_frame(8'h55, 1'b0, 4);
        repeat (8) @(negedge clk);
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'hE) begin
            miscompares++;
            $display("FAIL framing_status: got %h expected e", rd);
        end
        bus_read(32'd1, rd);
        vectors++;
        if (rd !== 32'h22) begin
            miscompares++;
            $display("FAIL framing_data_kept: got %h expected 22", rd);
        end
        bus_write(32'd3, 32'h2);
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL clear_errors: got %h expected 2", rd);
        end
        bus_write(32'd3, 32'h1);
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL clear_valid: got %h expected 0", rd);
        end
    endtask

    task automatic test_glitch_clamp();
        logic [31:0] rd;
        bus_write(32'd4, 32'd8);
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL glitch_status: got %h expected 0", rd);
        end
        bus_read(32'd1, rd);
        vectors++;
        if (rd !== 32'h22) begin
            miscompares++;
            $display("FAIL glitch_data: got %h expected 22", rd);
        end
        send_frame(8'h81, 1'b1, 8);
        repeat (3) @(negedge clk);
        bus_read(32'd1, rd);
        vectors++;
        if (rd !== 32'h81) begin
            miscompares++;
            $display("FAIL div8_data: got %h expected 81", rd);
        end
        bus_write(32'd4, 32'd1);
        bus_read(32'd4, rd);
        vectors++;
        if (rd !== 32'd2) begin
            miscompares++;
            $display("FAIL clamp_div1: got %0d expected 2", rd);
        end
        bus_write(32'd4, 32'd0);
        bus_read(32'd4, rd);
        vectors++;
        if (rd !== 32'd2) begin
            miscompares++;
            $display("FAIL clamp_div0: got %0d expected 2", rd);
        end
        bus_write(32'd4, 32'd3);
        bus_read(32'd4, rd);
        vectors++;
        if (rd !== 32'd3) begin
            miscompares++;
            $display("FAIL div3: got %0d expected 3", rd);
        end
    endtask

    task automatic test_bus_decode();
        logic [31:0] rd;
        logic [31:0] addrs [4];
        // rx_valid=1, RXDATA=0x81 here, so zeros below come from decode.
        Select = 1'b0;
        Write  = 1'b0;
        Addr   = 32'd2;
        #1;
        vectors++;
        if (DataOut !== 32'h0) begin
            miscompares++;
            $display("FAIL nosel_status: got %h expected 0", DataOut);
        end
        Addr = 32'd1;
        #1;
        vectors++;
        if (DataOut !== 32'h0) begin
            miscompares++;
            $display("FAIL nosel_rxdata: got %h expected 0", DataOut);
        end
        addrs = '{32'd0, 32'd3, 32'd6, 32'd7};
        foreach (addrs[i]) begin
            bus_read(addrs[i], rd);
            vectors++;
            if (rd !== 32'h0) begin
                miscompares++;
                $display("FAIL read_zero addr %0d: got %h expected 0", addrs[i], rd);
            end
        end
        bus_read(32'hC, rd);
        vectors++;
        if (rd !== 32'd3) begin
            miscompares++;
            $display("FAIL alias_div: got %0d expected 3", rd);
        end
        bus_write(32'd5, 32'hFFFF_FFFF);
        @(negedge clk);
        Select = 1'b0;
        Write  = 1'b1;
        Addr   = 32'd4;
        DataIn = 32'h50;
        @(negedge clk);
        Write  = 1'b0;
        bus_read(32'd4, rd);
        vectors++;
        if (rd !== 32'd3) begin
            miscompares++;
            $display("FAIL ignored_write_div: got %0d expected 3", rd);
        end
        bus_read(32'd2, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL ignored_write_status: got %h expected 2", rd);
        end
        bus_read(32'd1, rd);
        vectors++;
        if (rd !== 32'h81) begin
            miscompares++;
            $display("FAIL ignored_write_rxdata: got %h expected 81", rd);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        bus_write(32'd0, 32'h00);
        repeat (2) @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_start_bit: got %b expected 0", tx);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_tx_next_edge: got %b expected 1", tx);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
    endtask

    // Hang guard.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        rx     = 1'b1;
        Select = 1'b0;
        Write  = 1'b0;
        Addr   = 32'd0;
        DataIn = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_tx_frame();
        test_rx_good();
        test_rx_overrun_framing();
        test_glitch_clamp();
        test_bus_decode();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
